// File: rtl/voice_period_meter_pkg.sv
// Shared constants, FSM encoding and small sample helpers for the voice period meter.
package voice_period_meter_pkg;

  localparam logic [7:0] MIDSCALE = 8'd128;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } fsm_t;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/schmitt_detect.sv
// Hysteresis comparator around mid-scale; emits a one-cycle pulse on each LOW->HIGH transition.
module schmitt_detect
  import voice_period_meter_pkg::*;
#(
  parameter int HYST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_en,
  output logic       rise
);

  localparam logic [8:0] HI_TH = {1'b0, MIDSCALE} + 9'(HYST);
  localparam logic [8:0] LO_TH = {1'b0, MIDSCALE} - 9'd1 - 9'(HYST);

  logic state_r;
  logic state_next_s;

  // Next comparator state; samples inside the band keep the previous decision
  always_comb begin
    state_next_s = state_r;
    if (sample_en) begin
      if ({1'b0, sample_in} >= HI_TH) begin
        state_next_s = 1'b1;
      end else if ({1'b0, sample_in} <= LO_TH) begin
        state_next_s = 1'b0;
      end else begin
        state_next_s = state_r;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // State register and edge pulse; reset HIGH so a LOW must precede the first edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= 1'b1;
      rise    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      rise    <= state_next_s & ~state_r;
    end
  end

endmodule

// File: rtl/voice_period_meter.sv
// Measures the fundamental period of an 8-bit voice waveform, averaged over 2^AVG_LOG2 periods,
// with per-window peak tracking and a no-signal timeout.
module voice_period_meter
  import voice_period_meter_pkg::*;
#(
  parameter int               CNT_W    = 24,
  parameter int               HYST     = 8,
  parameter int               AVG_LOG2 = 2,
  parameter logic [CNT_W-1:0] TIMEOUT  = 24'd5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sample_in,
  input  logic             sample_en,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic [7:0]       peak_max,
  output logic [7:0]       peak_min,
  output logic             no_signal
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int NPER_W = AVG_LOG2 + 1;
  localparam logic [NPER_W-1:0] NPER_FULL = NPER_W'(1) << AVG_LOG2;

  logic              rise;
  fsm_t              state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ACC_W-1:0]  acc_r;
  logic [NPER_W-1:0] nper_r;
  logic [7:0]        max_r;
  logic [7:0]        min_r;

  logic [ACC_W-1:0]  acc_sum_s;
  logic [NPER_W-1:0] nper_inc_s;
  logic [7:0]        max_now_s;
  logic [7:0]        min_now_s;

  schmitt_detect #(.HYST(HYST)) u_schmitt (
    .clk       (clk),
    .rst       (rst),
    .sample_in (sample_in),
    .sample_en (sample_en),
    .rise      (rise)
  );

  // Running sums and trackers including the current sample, used on report and normal update
  always_comb begin
    acc_sum_s  = acc_r + ACC_W'(cnt_r);
    nper_inc_s = nper_r + NPER_W'(1);
    if (sample_en) begin
      max_now_s = max8(max_r, sample_in);
      min_now_s = min8(min_r, sample_in);
    end else begin
      max_now_s = max_r;
      min_now_s = min_r;
    end
  end

  // Period measurement FSM with registered report outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      acc_r        <= '0;
      nper_r       <= '0;
      max_r        <= 8'd0;
      min_r        <= 8'd255;
      period_out   <= '0;
      period_valid <= 1'b0;
      peak_max     <= 8'd0;
      peak_min     <= 8'd255;
      no_signal    <= 1'b1;
    end else begin
      period_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise) begin
            cnt_r   <= CNT_W'(1);
            acc_r   <= '0;
            nper_r  <= '0;
            max_r   <= 8'd0;
            min_r   <= 8'd255;
            state_r <= MEASURE;
          end
        end
        MEASURE: begin
          // An edge takes priority over a timeout landing in the same cycle
          if (rise) begin
            cnt_r <= CNT_W'(1);
            if (nper_inc_s == NPER_FULL) begin
              period_out   <= CNT_W'(acc_sum_s >> AVG_LOG2);
              peak_max     <= max_now_s;
              peak_min     <= min_now_s;
              period_valid <= 1'b1;
              no_signal    <= 1'b0;
              acc_r        <= '0;
              nper_r       <= '0;
              max_r        <= 8'd0;
              min_r        <= 8'd255;
            end else begin
              acc_r  <= acc_sum_s;
              nper_r <= nper_inc_s;
              max_r  <= max_now_s;
              min_r  <= min_now_s;
            end
          end else if (cnt_r == TIMEOUT) begin
            no_signal  <= 1'b1;
            period_out <= '0;
            acc_r      <= '0;
            nper_r     <= '0;
            max_r      <= 8'd0;
            min_r      <= 8'd255;
            state_r    <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            max_r <= max_now_s;
            min_r <= min_now_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_period_meter.sv
// Scoreboard bench for voice_period_meter: expected reports are queued with the stimulus and
// compared when period_valid strobes.
module tb_voice_period_meter;

  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       sample_in = 8'd0;
  logic             sample_en = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic [7:0]       peak_max;
  logic [7:0]       peak_min;
  logic             no_signal;

  typedef struct {
    logic [CNT_W-1:0] per;
    logic [7:0]       pmax;
    logic [7:0]       pmin;
  } rpt_t;

  rpt_t exp_q[$];
  int   rpt_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  voice_period_meter #(
    .CNT_W    (CNT_W),
    .HYST     (8),
    .AVG_LOG2 (2),
    .TIMEOUT  (24'd1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_en    (sample_en),
    .period_out   (period_out),
    .period_valid (period_valid),
    .peak_max     (peak_max),
    .peak_min     (peak_min),
    .no_signal    (no_signal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every report strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && period_valid) begin
      rpt_cyc_q.push_back(cyc);
      check("report_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        rpt_t e;
        e = exp_q.pop_front();
        check("period_out", 32'(period_out), 32'(e.per));
        check("peak_max", 32'(peak_max), 32'(e.pmax));
        check("peak_min", 32'(peak_min), 32'(e.pmin));
        check("no_signal_on_report", 32'(no_signal), 32'd0);
      end
    end
  end

  task automatic step(input logic [7:0] s, input logic e);
    sample_in = s;
    sample_en = e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sq(input int k, input int half);
    return ((k % (2 * half)) < half) ? 8'hFF : 8'h00;
  endfunction

  task automatic push_exp(input int per, input int pmax, input int pmin);
    rpt_t e;
    e.per  = CNT_W'(per);
    e.pmax = 8'(pmax);
    e.pmin = 8'(pmin);
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    sample_in = 8'd0;
    sample_en = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rst_period"}, 32'(period_out), 32'd0);
    check({tag, "_rst_valid"}, 32'(period_valid), 32'd0);
    check({tag, "_rst_max"}, 32'(peak_max), 32'd0);
    check({tag, "_rst_min"}, 32'(peak_min), 32'd255);
    check({tag, "_rst_nosig"}, 32'(no_signal), 32'd1);
    rst = 1'b0;
    rpt_cyc_q.delete();
  endtask

  task automatic drain(input string tag);
    check({tag, "_all_reports_seen"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int arm_cyc;
    int last_cyc;
    int nosig_cyc;
    int bad;
    logic [7:0] v;

    // 1: sawtooth, period 256, full-range peaks
    do_reset("saw");
    push_exp(256, 255, 0);
    for (int k = 0; k < 1170; k++) step(8'(k), 1'b1);
    check("saw_nosig", 32'(no_signal), 32'd0);
    drain("saw");

    // 2: square period 100, three windows spaced 400 clk
    do_reset("sq");
    for (int i = 0; i < 3; i++) push_exp(100, 255, 0);
    for (int k = 0; k < 1400; k++) step(sq(k, 50), 1'b1);
    drain("sq");
    check("sq_report_count", 32'(rpt_cyc_q.size()), 32'd3);
    if (rpt_cyc_q.size() == 3) begin
      check("sq_spacing_1", 32'(rpt_cyc_q[1] - rpt_cyc_q[0]), 32'd400);
      check("sq_spacing_2", 32'(rpt_cyc_q[2] - rpt_cyc_q[1]), 32'd400);
    end

    // 3: noise inside the hysteresis band never measures anything
    do_reset("noise");
    bad = 0;
    for (int k = 0; k < 5000; k++) begin
      step(8'($urandom_range(131, 124)), 1'b1);
      if (period_valid || !no_signal || period_out != '0) bad++;
    end
    check("noise_quiet_cycles_bad", 32'(bad), 32'd0);
    drain("noise");

    // 4: two windows, then silence -> timeout exactly 1000 clk after last edge, then restart
    do_reset("tmo");
    push_exp(100, 255, 0);
    push_exp(100, 255, 0);
    last_cyc = 0;
    for (int k = 0; k < 950; k++) begin
      step(sq(k, 50), 1'b1);
      if (k == 900) last_cyc = cyc;
    end
    drain("tmo_windows");
    nosig_cyc = -1;
    for (int k = 0; k < 1200; k++) begin
      step(8'd128, 1'b1);
      if (no_signal && nosig_cyc < 0) nosig_cyc = cyc;
    end
    check("tmo_nosig_time", 32'(nosig_cyc), 32'(last_cyc + 1001));
    check("tmo_period_cleared", 32'(period_out), 32'd0);
    check("tmo_nosig_held", 32'(no_signal), 32'd1);
    rpt_cyc_q.delete();
    push_exp(100, 255, 0);
    arm_cyc = 0;
    for (int k = 0; k < 520; k++) begin
      step(sq(k, 50), 1'b1);
      if (k == 100) arm_cyc = cyc;
    end
    drain("tmo_restart");
    check("tmo_restart_count", 32'(rpt_cyc_q.size()), 32'd1);
    if (rpt_cyc_q.size() == 1) check("tmo_restart_time", 32'(rpt_cyc_q[0]), 32'(arm_cyc + 401));
    check("tmo_restart_nosig", 32'(no_signal), 32'd0);

    // 5: sample_en toggling; disabled samples are decoys that must be ignored
    do_reset("en");
    push_exp(200, 8'hF0, 8'h10);
    for (int k = 0; k < 1020; k++) begin
      if ((k % 200) < 100) v = (k % 2 == 0) ? 8'hF0 : 8'h00;
      else                 v = (k % 2 == 0) ? 8'h10 : 8'hFF;
      step(v, (k % 2) == 0);
    end
    drain("en");

    // 6: reset mid-window after one report, then a fresh measurement
    do_reset("mid");
    push_exp(100, 255, 0);
    for (int k = 0; k < 730; k++) step(sq(k, 50), 1'b1);
    drain("mid_pre");
    check("mid_pre_period", 32'(period_out), 32'd100);
    do_reset("mid");
    push_exp(100, 255, 0);
    arm_cyc = 0;
    for (int k = 0; k < 520; k++) begin
      step(sq(k, 50), 1'b1);
      if (k == 100) arm_cyc = cyc;
    end
    drain("mid_post");
    check("mid_post_count", 32'(rpt_cyc_q.size()), 32'd1);
    if (rpt_cyc_q.size() == 1) check("mid_post_time", 32'(rpt_cyc_q[0]), 32'(arm_cyc + 401));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
